// File: rtl/shannon_bit_packer.sv
// Packs MSB-first variable-length codewords (0..8 bits) into bytes through a 16-bit left-justified buffer.
// Latency: bits accepted at a rising edge are visible on out_byte/out_valid after that edge; no comb in->out path.
// Backpressure: in_ready drops when fill > 8 or during a flush; out_* hold stable while out_ready is low.
module shannon_bit_packer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic [7:0]  in_code,
  input  logic [3:0]  in_len,
  output logic        in_ready,
  input  logic        flush,
  output logic        out_valid,
  output logic [7:0]  out_byte,
  input  logic        out_ready,
  output logic        out_last,
  output logic        flush_done,
  output logic [15:0] total_bits
);

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] buf_q, buf_d;
  logic [4:0]  fill_q, fill_d;
  logic [15:0] total_q, total_d;
  logic        flush_done_q, flush_done_d;

  logic        partial;
  logic        accept;
  logic        consume;
  logic [3:0]  len_c;
  logic [7:0]  code_m;
  logic [4:0]  shamt;
  logic [15:0] ins;

  // All handshake outputs come straight from registers so no input reaches an output combinationally.
  // Bits below the fill level are kept at zero, so a padded partial byte needs no extra masking.
  assign partial    = (fill_q != 5'd0) && (fill_q < 5'd8);
  assign in_ready   = (state_q == RUN) && (fill_q <= 5'd8);
  assign out_valid  = (fill_q >= 5'd8) || ((state_q == FLUSH) && partial);
  assign out_last   = (state_q == FLUSH) && partial;
  assign out_byte   = buf_q[15:8];
  assign flush_done = flush_done_q;
  assign total_bits = total_q;

  assign accept  = in_valid && in_ready;
  assign consume = out_valid && out_ready;
  assign len_c   = (in_len > 4'd8) ? 4'd8 : in_len;
  // Drop any stray bits above the codeword length so they cannot pollute earlier buffered bits.
  assign code_m  = in_code & ~(8'hFF << len_c);

  // Next-state: drain a byte first, then append the new codeword below the remaining bits, then advance the FSM.
  always_comb begin
    state_d      = state_q;
    buf_d        = buf_q;
    fill_d       = fill_q;
    total_d      = total_q;
    flush_done_d = 1'b0;
    shamt        = 5'd0;
    ins          = 16'h0000;

    if (consume) begin
      if (out_last) begin
        buf_d  = 16'h0000;
        fill_d = 5'd0;
      end else begin
        buf_d  = {buf_q[7:0], 8'h00};
        fill_d = fill_q - 5'd8;
      end
    end

    // Accept only happens with fill <= 8, so fill_d + len never exceeds 16 and the shift stays in range.
    if (accept) begin
      shamt   = 5'd16 - fill_d - {1'b0, len_c};
      ins     = {8'h00, code_m} << shamt;
      buf_d   = buf_d | ins;
      fill_d  = fill_d + {1'b0, len_c};
      total_d = total_q + {12'h000, len_c};
    end

    case (state_q)
      RUN: begin
        if (flush) begin
          state_d = FLUSH;
        end
      end
      FLUSH: begin
        // Leave once the padded last byte is taken, or immediately if nothing was left to emit.
        if ((consume && out_last) || (fill_q == 5'd0)) begin
          state_d      = RUN;
          fill_d       = 5'd0;
          flush_done_d = 1'b1;
        end
      end
      default: begin
        state_d = RUN;
      end
    endcase
  end

  // State registers; reset discards buffered bits and any flush in progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= RUN;
      buf_q        <= 16'h0000;
      fill_q       <= 5'd0;
      total_q      <= 16'h0000;
      flush_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      buf_q        <= buf_d;
      fill_q       <= fill_d;
      total_q      <= total_d;
      flush_done_q <= flush_done_d;
    end
  end

endmodule
